// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the uCaspian host-bound output path.
package ucaspian_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_STREAM
  } arb_state_t;

  localparam int BYTE_W  = 8;
  localparam int MAX_SRC = 8;

  // Index width for a source count; never narrower than one bit.
  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(MAX_SRC)-1:0] src_idx_t;

endpackage

// File: rtl/ucaspian_rr_pick.sv
// Combinational round-robin finder: first asserted request at or after ptr, wrapping.
module ucaspian_rr_pick
  import ucaspian_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]               req,
  input  logic [src_idx_w(NUM_SRC)-1:0]    ptr,
  output logic                             gnt_vld,
  output logic [src_idx_w(NUM_SRC)-1:0]    idx
);

  localparam int IDX_W = src_idx_w(NUM_SRC);

  always_comb begin
    gnt_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      int unsigned c;
      // ptr is always < NUM_SRC, so a single subtraction wraps the sum
      c = 32'(ptr) + k;
      if (c >= NUM_SRC) c = c - NUM_SRC;
      if (!gnt_vld && req[IDX_W'(c)]) begin
        gnt_vld = 1'b1;
        idx     = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/ucaspian_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the host read channel among NUM_SRC sources.
module ucaspian_tx_arbiter
  import ucaspian_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = BYTE_W
) (
  input  logic                           sys_clk,
  input  logic                           reset,
  input  logic [NUM_SRC*DATA_W-1:0]      src_data,
  input  logic [NUM_SRC-1:0]             src_vld,
  input  logic [NUM_SRC-1:0]             src_last,
  output logic [NUM_SRC-1:0]             src_rdy,
  output logic [DATA_W-1:0]              read_data,
  output logic                           read_vld,
  input  logic                           read_rdy,
  output logic                           busy,
  output logic [src_idx_w(NUM_SRC)-1:0]  grant_id
);

  localparam int IDX_W = src_idx_w(NUM_SRC);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvld_q;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic              out_free;
  logic              xfer;
  logic              last_xfer;
  logic [DATA_W-1:0] sel_data;

  ucaspian_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req     (src_vld),
    .ptr     (rr_ptr_q),
    .gnt_vld (pick_vld),
    .idx     (pick_idx)
  );

  assign out_free = !rvld_q || read_rdy;

  always_comb begin
    src_rdy = '0;
    if (state_q == ARB_STREAM && out_free) src_rdy[grant_q] = 1'b1;
  end

  assign xfer      = src_rdy[grant_q] && src_vld[grant_q];
  assign last_xfer = xfer && src_last[grant_q];
  assign sel_data  = src_data[grant_q*DATA_W +: DATA_W];

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
    end else begin
      // A new byte may reload the register in the same cycle the host drains it
      if (xfer) begin
        rdata_q <= sel_data;
        rvld_q  <= 1'b1;
      end else if (read_rdy) begin
        rvld_q  <= 1'b0;
      end

      case (state_q)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            state_q <= ARB_STREAM;
          end
        end
        ARB_STREAM: begin
          if (last_xfer) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign read_data = rdata_q;
  assign read_vld  = rvld_q;
  assign busy      = (state_q == ARB_STREAM);
  assign grant_id  = grant_q;

endmodule
